// File: rtl/pamiec_data.sv
// Paged byte-wide data memory: an 8-bit window onto 16 pages of 256 bytes,
// with the window's top address acting as the page-select register.
module pamiec_data #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 8,
  parameter int STRONY_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_mem,
  input  logic [ADDR_WIDTH-1:0] adres,
  input  logic [DATA_WIDTH-1:0] dane,
  output logic [DATA_WIDTH-1:0] out
);

  localparam int PHYS_W = STRONY_WIDTH + ADDR_WIDTH;
  localparam int DEPTH  = 1 << PHYS_W;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [STRONY_WIDTH-1:0] strona;
  logic                    is_page_reg;
  logic [PHYS_W-1:0]       phys;

  assign is_page_reg = &adres;
  assign phys        = {strona, adres};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      strona <= '0;
    end else if (wr_mem && is_page_reg) begin
      strona <= dane[STRONY_WIDTH-1:0];
    end
  end

  // RAM is never reset; rst only blocks writes that coincide with it.
  always_ff @(posedge clk) begin
    if (wr_mem && !rst && !is_page_reg) begin
      mem[phys] <= dane;
    end
  end

  // Write-through has priority so the CPU sees store data in the same cycle.
  always_comb begin
    out = mem[phys];
    if (wr_mem) begin
      out = dane;
    end else if (is_page_reg) begin
      out = '0;
      out[STRONY_WIDTH-1:0] = strona;
    end
  end

endmodule

// File: tb/tb_pamiec_data.sv
// Scoreboard bench for pamiec_data: directed sequence plus random traffic
// against a page/byte-map reference model.
module tb_pamiec_data;

  logic       clk;
  logic       rst;
  logic       wr_mem;
  logic [7:0] adres;
  logic [7:0] dane;
  logic [7:0] dout;

  pamiec_data #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .STRONY_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .wr_mem(wr_mem), .adres(adres), .dane(dane), .out(dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // reference model: current page and a sparse map of physical bytes
  int         page_m = 0;
  logic [7:0] mem_m [int];
  logic       pend_wr = 1'b0;
  logic [7:0] pend_a, pend_d;

  // monitor: output is combinational, so it is valid mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (dout !== e.exp) begin
        errors++;
        $display("FAIL %s: out=%h expected=%h", e.name, dout, e.exp);
      end
    end
  end

  task automatic cyc(input string name, input logic r, input logic w,
                     input logic [7:0] a, input logic [7:0] d, input bit chk);
    exp_t e;
    int   idx;
    @(posedge clk);
    if (pend_wr) begin
      if (pend_a == 8'hFF) page_m = int'(pend_d[3:0]);
      else mem_m[page_m * 256 + int'(pend_a)] = pend_d;
    end
    #1;
    rst = r; wr_mem = w; adres = a; dane = d;
    if (r) page_m = 0;
    pend_wr = w && !r;
    pend_a  = a;
    pend_d  = d;
    idx = page_m * 256 + int'(a);
    e.name = name;
    if (w) e.exp = d;
    else if (a == 8'hFF) e.exp = 8'(page_m);
    else if (mem_m.exists(idx)) e.exp = mem_m[idx];
    else chk = 1'b0;
    if (chk) exp_q.push_back(e);
  endtask

  task automatic wr(input string name, input logic [7:0] a, input logic [7:0] d);
    cyc(name, 1'b0, 1'b1, a, d, 1'b1);
  endtask

  task automatic rd(input string name, input logic [7:0] a);
    cyc(name, 1'b0, 1'b0, a, 8'h00, 1'b1);
  endtask

  initial begin
    logic [7:0] addrs[4];
    logic [7:0] vals[4];
    rst = 1'b1; wr_mem = 1'b0; adres = 8'h00; dane = 8'h00;

    // reset held 2 cycles while attempting a page write that must be ignored
    cyc("rst_wthru", 1'b1, 1'b1, 8'hFF, 8'h07, 1'b1);
    cyc("rst_wthru2", 1'b1, 1'b1, 8'hFF, 8'h07, 1'b1);
    rd("reset_page", 8'hFF);

    addrs = '{8'd0, 8'd100, 8'd200, 8'd254};
    vals  = '{8'h01, 8'hAA, 8'hBB, 8'hCC};
    for (int i = 0; i < 4; i++) wr("p0_wr", addrs[i], vals[i]);
    for (int i = 0; i < 4; i++) rd("p0_rd", addrs[i]);
    wr("pg5_wr", 8'hFF, 8'h05);
    rd("pg5_rd", 8'hFF);
    wr("p5_wr", 8'd0, 8'h11);
    wr("p5_wr", 8'd100, 8'h55);
    wr("p5_wr", 8'd200, 8'h66);
    rd("p5_rd0", 8'd0);
    rd("p5_rd100", 8'd100);
    rd("p5_rd200", 8'd200);
    wr("pg0_wr", 8'hFF, 8'h00);
    rd("iso_rd0", 8'd0);
    rd("iso_rd100", 8'd100);

    wr("wthru", 8'd80, 8'h77);
    rd("wthru_rd", 8'd80);

    wr("pg3_wr", 8'hFF, 8'h03);
    wr("ovw_1", 8'd90, 8'h33);
    wr("ovw_2", 8'd90, 8'h44);
    rd("ovw_rd", 8'd90);

    wr("pg9_wthru", 8'hFF, 8'h09);
    rd("pg9_rd", 8'hFF);
    wr("pg9_data", 8'd50, 8'h99);
    rd("pg9_data_rd", 8'd50);

    // upper dane bits must be dropped on a page write
    wr("pg_mask_wr", 8'hFF, 8'hE6);
    rd("pg_mask_rd", 8'hFF);

    for (int p = 0; p < 16; p++) begin
      wr("all_pg", 8'hFF, 8'(p));
      wr("all_wr", 8'd50, 8'(8'h10 + p));
      rd("all_rd", 8'd50);
    end
    wr("all_pg0", 8'hFF, 8'h00);
    rd("all_pg0_rd", 8'hFF);
    for (int p = 0; p < 16; p++) begin
      wr("all_pg_re", 8'hFF, 8'(p));
      rd("all_keep", 8'd50);
    end

    // asynchronous reset: page must read 0 before any clock edge
    wr("ar_pg", 8'hFF, 8'h0B);
    cyc("async_rst", 1'b1, 1'b0, 8'hFF, 8'h00, 1'b1);
    cyc("async_rst2", 1'b1, 1'b1, 8'd50, 8'h5A, 1'b1);
    rd("after_rst_pg", 8'hFF);
    rd("rst_no_wr", 8'd50);

    for (int n = 0; n < 400; n++) begin
      logic       w;
      logic [7:0] a;
      logic [7:0] d;
      w = ($urandom_range(0, 2) != 0);
      a = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 15) * 16 + $urandom_range(0, 3));
      d = 8'($urandom);
      if (!w && a != 8'hFF && !mem_m.exists(page_m * 256 + int'(a))) a = 8'hFF;
      cyc("rand", 1'b0, w, a, d, 1'b1);
    end

    cyc("idle", 1'b0, 1'b0, 8'hFF, 8'h00, 1'b1);
    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
